// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage front end for the data memory. Each pipeline memory request goes
//   to one of three places:
//   - the synchronous-read dmem BRAM;
//   - the on-board MMIO page (LED register, synchronised switch inputs);
//   - nowhere, if it is misaligned. It is then flagged on `misalign` and
//     suppressed.
//   dmem loads stall the pipeline until the registered read data is ready. The
//   data is then presented on the response port for one cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/we      request present; 1=store, 0=load
//   req_addr/wd       byte address, store data
//   req_dmtype        000 W, 001 H, 010 HU, 011 B, 100 BU
//   dmem_we/addr/wd/dmtype   dmem command; dmem_rd is the formatted read data
//   sw_in             raw asynchronous board switches
//   led_out           LED register
//   stall             freeze IF..MEM; req_* are held stable while high
//   misalign          one-cycle exception pulse; the access is not performed
//   resp_valid/rdata  load result toward MEM/WB
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_F000,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned SW_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wd,
    input  logic [2:0]       req_dmtype,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wd,
    output logic [2:0]       dmem_dmtype,
    input  logic [31:0]      dmem_rd,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out,
    output logic             stall,
    output logic             misalign,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata
);

    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    localparam logic [2:0]  DT_W    = 3'b000;
    localparam logic [2:0]  DT_H    = 3'b001;
    localparam logic [2:0]  DT_HU   = 3'b010;
    localparam logic [11:0] OFF_LED = 12'h000;
    localparam logic [11:0] OFF_SW  = 12'h004;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wd_q, wd_d;
    logic [2:0]       dmtype_q, dmtype_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;

    logic        is_mmio;
    logic        is_misalign;
    logic        mmio_load;
    logic [11:0] mmio_off;
    logic [31:0] mmio_rdata;

    assign is_mmio  = (req_addr[31:12] == MMIO_BASE[31:12]);
    assign mmio_off = req_addr[11:0];

    // Misalignment is checked before MMIO decode, so a misaligned MMIO access
    // is suppressed as well.
    always_comb begin
        is_misalign = 1'b0;
        if (req_dmtype == DT_W)
            is_misalign = (req_addr[1:0] != 2'b00);
        else if (req_dmtype == DT_H || req_dmtype == DT_HU)
            is_misalign = req_addr[0];
    end

    // MMIO reads are zero-extended whatever the DMType. Unmapped offsets read
    // back as 0.
    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OFF_LED: mmio_rdata = 32'(led_q);
            OFF_SW:  mmio_rdata = 32'(sw_sync_q);
            default: mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wd_d        = wd_q;
        dmtype_d    = dmtype_q;
        rdata_d     = rdata_q;
        led_d       = led_q;
        stall       = 1'b0;
        misalign    = 1'b0;
        resp_valid  = 1'b0;
        dmem_we     = 1'b0;
        mmio_load   = 1'b0;
        dmem_addr   = req_addr;
        dmem_wd     = req_wd;
        dmem_dmtype = req_dmtype;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (is_misalign) begin
                        misalign = 1'b1;
                    end else if (is_mmio) begin
                        if (req_we) begin
                            if (mmio_off == OFF_LED)
                                led_d = req_wd[LED_W-1:0];
                        end else begin
                            // Single-cycle MMIO load. rdata_q is also updated
                            // so the response holds this value afterwards.
                            mmio_load  = 1'b1;
                            resp_valid = 1'b1;
                            rdata_d    = mmio_rdata;
                        end
                    end else if (req_we) begin
                        dmem_we = 1'b1;
                    end else begin
                        // dmem load: keep a private copy of the request so
                        // the dmem address stays put while the BRAM answers.
                        stall    = 1'b1;
                        addr_d   = req_addr;
                        wd_d     = req_wd;
                        dmtype_d = req_dmtype;
                        cnt_d    = CNT_W'(LOAD_LAT - 1);
                        state_d  = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                dmem_addr   = addr_q;
                dmem_wd     = wd_q;
                dmem_dmtype = dmtype_q;
                stall       = 1'b1;
                if (cnt_q == '0) begin
                    rdata_d = dmem_rd;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DONE: begin
                // The pipeline still shows the same request this cycle. It
                // is retired here, not reissued.
                dmem_addr   = addr_q;
                dmem_wd     = wd_q;
                dmem_dmtype = dmtype_q;
                resp_valid  = 1'b1;
                state_d     = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign resp_rdata = mmio_load ? mmio_rdata : rdata_q;
    assign led_out    = led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            dmtype_q  <= '0;
            rdata_q   <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            dmtype_q  <= dmtype_d;
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int LAT = 1;

    logic        clk = 0;
    logic        rst;
    always #5 clk = ~clk;

    // ---------------- LOAD_LAT=1 instance ----------------
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wd;
    logic [2:0]  req_dmtype;
    logic        dmem_we;
    logic [31:0] dmem_addr, dmem_wd, dmem_rd;
    logic [2:0]  dmem_dmtype;
    logic [15:0] sw_in, led_out;
    logic        stall, misalign, resp_valid;
    logic [31:0] resp_rdata;

    mem_access_ctrl #(.LOAD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wd(req_wd), .req_dmtype(req_dmtype),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wd(dmem_wd),
        .dmem_dmtype(dmem_dmtype), .dmem_rd(dmem_rd),
        .sw_in(sw_in), .led_out(led_out),
        .stall(stall), .misalign(misalign),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata)
    );

    // ---------------- LOAD_LAT=3 instance ----------------
    logic        r3_valid, r3_we;
    logic [31:0] r3_addr, r3_wd;
    logic [2:0]  r3_dmtype;
    logic        d3_we;
    logic [31:0] d3_addr, d3_wd, d3_rd;
    logic [2:0]  d3_dmtype;
    logic [15:0] led3;
    logic        stall3, mis3, rv3;
    logic [31:0] rd3;

    mem_access_ctrl #(.LOAD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(r3_valid), .req_we(r3_we), .req_addr(r3_addr),
        .req_wd(r3_wd), .req_dmtype(r3_dmtype),
        .dmem_we(d3_we), .dmem_addr(d3_addr), .dmem_wd(d3_wd),
        .dmem_dmtype(d3_dmtype), .dmem_rd(d3_rd),
        .sw_in(sw_in), .led_out(led3),
        .stall(stall3), .misalign(mis3),
        .resp_valid(rv3), .resp_rdata(rd3)
    );

    // ---------------- memory semantics shared by BRAM and reference ----------
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] dt,
                                        input logic [1:0] a);
        logic [15:0] h;
        logic [7:0]  b;
        h = 16'(w >> (16 * int'(a[1])));
        b = 8'(w >> (8 * int'(a)));
        case (dt)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [2:0] dt, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        case (dt)
            3'd1, 3'd2: r[16*int'(a[1]) +: 16] = wd[15:0];
            3'd3, 3'd4: r[8*int'(a) +: 8] = wd[7:0];
            default:    r = wd;
        endcase
        return r;
    endfunction

    // BRAM models driven purely by the DUT's dmem outputs.
    logic [31:0] mem  [64];
    logic [31:0] mem3 [64];
    logic [31:0] pipe3 [3];

    always @(posedge clk) begin
        if (dmem_we) mem[dmem_addr[7:2]] <= st_merge(mem[dmem_addr[7:2]], dmem_wd, dmem_dmtype, dmem_addr[1:0]);
        dmem_rd <= fmt(mem[dmem_addr[7:2]], dmem_dmtype, dmem_addr[1:0]);
    end

    always @(posedge clk) begin
        if (d3_we) mem3[d3_addr[7:2]] <= st_merge(mem3[d3_addr[7:2]], d3_wd, d3_dmtype, d3_addr[1:0]);
        pipe3[0] <= fmt(mem3[d3_addr[7:2]], d3_dmtype, d3_addr[1:0]);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign d3_rd = pipe3[2];

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] ref_mem [64];
    logic [15:0] m_led, m_sw;
    logic [31:0] m_last;

    task automatic model_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] dt, output bit e_mis, output int e_stall,
                             output bit e_resp, output logic [31:0] e_rd, output bit e_we);
        e_mis = 0; e_stall = 0; e_resp = 0; e_rd = 32'h0; e_we = 0;
        if ((dt == 3'd0 && a[1:0] != 2'b00) || ((dt == 3'd1 || dt == 3'd2) && a[0])) begin
            e_mis = 1;
        end else if (a[31:12] == 20'hFFFFF) begin
            if (we) begin
                if (a[11:0] == 12'h000) m_led = wd[15:0];
            end else begin
                e_resp = 1;
                e_rd = (a[11:0] == 12'h000) ? {16'h0, m_led} :
                       (a[11:0] == 12'h004) ? {16'h0, m_sw} : 32'h0;
            end
        end else if (we) begin
            e_we = 1;
            ref_mem[a[7:2]] = st_merge(ref_mem[a[7:2]], wd, dt, a[1:0]);
        end else begin
            e_stall = LAT + 1;
            e_resp  = 1;
            e_rd    = fmt(ref_mem[a[7:2]], dt, a[1:0]);
        end
        if (e_resp) m_last = e_rd;
    endtask

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] dt, input bit e_mis, input int e_stall,
                           input bit e_resp, input logic [31:0] e_rd, input bit e_we,
                           input logic [15:0] e_led);
        int  stalls = 0;
        int  pulses = 0;
        bit  done   = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wd = wd; req_dmtype = dt;
        for (int c = 0; c < LAT + 4 && !done; c++) begin
            @(negedge clk);
            chk("misalign", 32'(misalign), (c == 0) ? 32'(e_mis) : 32'h0);
            chk("dmem_addr", dmem_addr, a);
            chk("dmem_dmtype", 32'(dmem_dmtype), 32'(dt));
            if (dmem_we) begin
                pulses++;
                chk("dmem_wd", dmem_wd, wd);
            end
            if (stall) stalls++;
            else begin
                done = 1;
                chk("resp_valid", 32'(resp_valid), 32'(e_resp));
                if (e_resp) chk("resp_rdata", resp_rdata, e_rd);
            end
            @(posedge clk); #1;
        end
        chk("stall_released", 32'(done), 32'h1);
        chk("stall_cycles", 32'(stalls), 32'(e_stall));
        chk("dmem_we_pulses", 32'(pulses), 32'(e_we));
        chk("led_out", 32'(led_out), 32'(e_led));
        req_valid = 0;
    endtask

    task automatic idle_cycle();
        req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wd = $urandom;
        req_dmtype = 3'($urandom_range(0, 4));
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'h0);
        chk("idle_misalign", 32'(misalign), 32'h0);
        chk("idle_resp_valid", 32'(resp_valid), 32'h0);
        chk("idle_dmem_we", 32'(dmem_we), 32'h0);
        chk("idle_rdata_hold", resp_rdata, m_last);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  dt;
        bit          e_mis;
        int          e_stall;
        bit          e_resp;
        logic [31:0] e_rd;
        bit          e_we;
        logic [15:0] e_led;
    } vec_t;

    vec_t tbl [18];

    initial begin
        bit          mis, rsp, wep;
        int          stl;
        logic [31:0] erd;

        tbl[0]  = '{1, 32'h10,       32'hDEADBEEF, 3'd0, 0, 0, 0, 32'h0,        1, 16'h0};
        tbl[1]  = '{0, 32'h10,       32'h0,        3'd0, 0, 2, 1, 32'hDEADBEEF, 0, 16'h0};
        tbl[2]  = '{0, 32'h13,       32'h0,        3'd1, 1, 0, 0, 32'h0,        0, 16'h0};
        tbl[3]  = '{0, 32'h12,       32'h0,        3'd0, 1, 0, 0, 32'h0,        0, 16'h0};
        tbl[4]  = '{1, 32'hFFFFF000, 32'h0000ABCD, 3'd0, 0, 0, 0, 32'h0,        0, 16'hABCD};
        tbl[5]  = '{0, 32'hFFFFF000, 32'h0,        3'd0, 0, 0, 1, 32'h0000ABCD, 0, 16'hABCD};
        tbl[6]  = '{0, 32'hFFFFF004, 32'h0,        3'd0, 0, 0, 1, 32'h000000F0, 0, 16'hABCD};
        tbl[7]  = '{0, 32'h11,       32'h0,        3'd3, 0, 2, 1, 32'hFFFFFFBE, 0, 16'hABCD};
        tbl[8]  = '{0, 32'h12,       32'h0,        3'd2, 0, 2, 1, 32'h0000DEAD, 0, 16'hABCD};
        tbl[9]  = '{0, 32'h12,       32'h0,        3'd1, 0, 2, 1, 32'hFFFFDEAD, 0, 16'hABCD};
        tbl[10] = '{0, 32'h13,       32'h0,        3'd4, 0, 2, 1, 32'h000000DE, 0, 16'hABCD};
        tbl[11] = '{1, 32'hFFFFF001, 32'h00001111, 3'd1, 1, 0, 0, 32'h0,        0, 16'hABCD};
        tbl[12] = '{0, 32'hFFFFF008, 32'h0,        3'd0, 0, 0, 1, 32'h0,        0, 16'hABCD};
        tbl[13] = '{1, 32'hFFFFF004, 32'h00001234, 3'd0, 0, 0, 0, 32'h0,        0, 16'hABCD};
        tbl[14] = '{1, 32'hFFFFF000, 32'h12345678, 3'd3, 0, 0, 0, 32'h0,        0, 16'h5678};
        tbl[15] = '{0, 32'hFFFFF000, 32'h0,        3'd3, 0, 0, 1, 32'h00005678, 0, 16'h5678};
        tbl[16] = '{1, 32'h16,       32'h1234BEEF, 3'd1, 0, 0, 0, 32'h0,        1, 16'h5678};
        tbl[17] = '{0, 32'h14,       32'h0,        3'd0, 0, 2, 1, 32'hBEEF0000, 0, 16'h5678};

        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0; mem3[i] = 32'h0;
        end
        mem3[8] = 32'h11228344;
        m_led = 16'h0; m_sw = 16'h00F0; m_last = 32'h0;
        sw_in = 16'h00F0;
        req_valid = 0; req_we = 0; req_addr = 0; req_wd = 0; req_dmtype = 0;
        r3_valid = 0; r3_we = 0; r3_addr = 0; r3_wd = 0; r3_dmtype = 0;

        // Reset state.
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_dmem_we", 32'(dmem_we), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_stall3", 32'(stall3), 32'h0);
        @(posedge clk); #1;
        rst = 0;
        repeat (3) idle_cycle();

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            model_req(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].dt, mis, stl, rsp, erd, wep);
            run_req(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].dt, tbl[i].e_mis,
                    tbl[i].e_stall, tbl[i].e_resp, tbl[i].e_rd, tbl[i].e_we, tbl[i].e_led);
            if (i % 3 == 0) idle_cycle();
        end

        // Reset in the middle of a dmem load.
        req_valid = 1; req_we = 0; req_addr = 32'h10; req_dmtype = 3'd0;
        @(negedge clk);
        chk("midrst_stall_idle", 32'(stall), 32'h1);
        @(posedge clk); #1;
        rst = 1;
        req_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        m_led = 16'h0; m_last = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_stall", 32'(stall), 32'h0);
            chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
            chk("midrst_led", 32'(led_out), 32'h0);
            chk("midrst_rdata", resp_rdata, 32'h0);
            @(posedge clk); #1;
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [31:0] a, wd;
            logic [2:0]  dt;
            if ($urandom_range(0, 7) == 0) begin
                sw_in = 16'($urandom);
                repeat (3) idle_cycle();
                m_sw = sw_in;
            end
            we = 1'($urandom);
            wd = $urandom;
            dt = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       a = 32'hFFFFF000;
                    1:       a = 32'hFFFFF004;
                    2:       a = 32'hFFFFF008;
                    default: a = 32'hFFFFFFFC;
                endcase
                if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
            end else begin
                a = {24'h0, 8'($urandom)};
            end
            model_req(we, a, wd, dt, mis, stl, rsp, erd, wep);
            run_req(we, a, wd, dt, mis, stl, rsp, erd, wep, m_led);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // LOAD_LAT=3: lb 0x21.
        begin
            int  stalls3 = 0;
            bit  got     = 0;
            r3_valid = 1; r3_we = 0; r3_addr = 32'h21; r3_dmtype = 3'd3;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                chk("lat3_dmem_addr", d3_addr, 32'h21);
                chk("lat3_dmem_we", 32'(d3_we), 32'h0);
                if (stall3) stalls3++;
                else begin
                    got = 1;
                    chk("lat3_resp_valid", 32'(rv3), 32'h1);
                    chk("lat3_resp_rdata", rd3, 32'hFFFFFF83);
                end
                @(posedge clk); #1;
            end
            r3_valid = 0;
            chk("lat3_released", 32'(got), 32'h1);
            chk("lat3_stall_cycles", 32'(stalls3), 32'd4);
            @(negedge clk);
            chk("lat3_after_resp_valid", 32'(rv3), 32'h0);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
